// File: rtl/case_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : case_decode_pkg
// Description : Shared FSM encodings and decode constants for the shared
//               case-decoder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package case_decode_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DECODE = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    localparam logic [2:0] CODE_0 = 3'b000;
    localparam logic [2:0] CODE_1 = 3'b001;
    localparam logic [2:0] CODE_2 = 3'b010;

    localparam int DEFAULT_RES_C = 9;
    localparam int GRANT_CNT_W   = 8;

endpackage : case_decode_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts one past the
//               previous winner and wraps modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_pos       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_pos = int'(i_last_grant) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!w_found && i_req[IDX_W'(w_pos)]) begin
                w_found                   = 1'b1;
                o_grant[IDX_W'(w_pos)]    = 1'b1;
                o_grant_idx               = IDX_W'(w_pos);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/case_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : case_decode_arbiter
// Description : Round-robin sharing of one registered 3-bit case decoder among
//               NUM_REQ requesters. Optional grant counters: CASE_DECODE_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module case_decode_arbiter
    import case_decode_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int CODE_W      = 3,
    parameter int RES_W       = 4,
    parameter int DEFAULT_RES = DEFAULT_RES_C,
    parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_n,
    input  logic [NUM_REQ-1:0]             i_Req_Valid,
    input  logic [NUM_REQ*CODE_W-1:0]      i_Req_Code,
    output logic [NUM_REQ-1:0]             o_Req_Ready,
    output logic                           o_Res_Valid,
    output logic [RES_W-1:0]               o_Res_Data,
    output logic [IDX_W-1:0]               o_Res_Id,
    input  logic                           i_Res_Ready,
    output logic [NUM_REQ*GRANT_CNT_W-1:0] o_Grant_Cnt
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   r_id;
    logic [CODE_W-1:0]  r_code;
    logic               r_res_valid;
    logic [RES_W-1:0]   r_res_data;
    logic [IDX_W-1:0]   r_res_id;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [CODE_W-1:0]  w_sel_code;
    logic [RES_W-1:0]   w_dec;
    logic               w_arb_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req        (i_Req_Valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Ready is only offered while arbitrating and never during reset.
    assign w_arb_en    = i_Rst_n && (r_state == ST_IDLE);
    assign o_Req_Ready = w_arb_en ? w_grant : '0;
    assign w_sel_code  = i_Req_Code[w_grant_idx*CODE_W +: CODE_W];

    // Upper code bits take part in the compare, so any non-zero high bit falls to default.
    always_comb begin
        w_dec = RES_W'(DEFAULT_RES);
        case (r_code)
            CODE_W'(CODE_0): w_dec = RES_W'(0);
            CODE_W'(CODE_1): w_dec = RES_W'(1);
            CODE_W'(CODE_2): w_dec = RES_W'(2);
            default:         w_dec = RES_W'(DEFAULT_RES);
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_code       <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_id     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_code       <= w_sel_code;
                        r_id         <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_res_data  <= w_dec;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_Res_Ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Res_Valid = r_res_valid;
    assign o_Res_Data  = r_res_data;
    assign o_Res_Id    = r_res_id;

`ifdef CASE_DECODE_ARB_STATS_EN
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_grant_cnt
            logic [GRANT_CNT_W-1:0] r_cnt;

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_n) begin
                    r_cnt <= '0;
                end else if (o_Req_Ready[k] && i_Req_Valid[k] && (r_cnt != {GRANT_CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_Grant_Cnt[k*GRANT_CNT_W +: GRANT_CNT_W] = r_cnt;
        end
    endgenerate
`else
    assign o_Grant_Cnt = '0;
`endif

endmodule : case_decode_arbiter
`default_nettype wire
